out: RTL and testbench

OUT -- requirements
Module: out

---
 rtl/mix_pkg.sv | 43 ++++
 rtl/uart_tx.sv | 71 +++++++
 rtl/out.sv | 164 ++++++++++++++++
 tb/tb_out.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// Shared constants for the MIX block printer: FSM state encoding and the
// MIX character code to ASCII translation.
package mix_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3;
    localparam logic [2:0] ST_NEXT = 3'd4;
    localparam logic [2:0] ST_EOL  = 3'd5;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;

    localparam int CHARS_PER_WORD = 5;

    // Codes 40..55 in order; the first character sits in the top byte.
    localparam logic [127:0] PUNCT_TABLE = ".,()+-*/=$<>@;:'";

    function automatic logic [7:0] mix_to_ascii(input logic [5:0] code);
        logic [7:0] c;
        logic [3:0] k;
        c = ASCII_UNKNOWN;
        k = code[3:0] - 4'd8;
        if (code == 6'd0) begin
            c = ASCII_SPACE;
        end else if (code <= 6'd9) begin
            c = 8'h41 + {2'b00, code - 6'd1};
        end else if (code >= 6'd11 && code <= 6'd19) begin
            c = 8'h4A + {2'b00, code - 6'd11};
        end else if (code >= 6'd22 && code <= 6'd29) begin
            c = 8'h53 + {2'b00, code - 6'd22};
        end else if (code >= 6'd30 && code <= 6'd39) begin
            c = 8'h30 + {2'b00, code - 6'd30};
        end else if (code >= 6'd40 && code <= 6'd55) begin
            c = PUNCT_TABLE[8 * (15 - int'(k)) +: 8];
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit,
// each held for BAUD_DIV clock cycles. Line idles high.
module uart_tx #(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       send,
    output logic       tx,
    output logic       ready
);
    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [8:0]       shift_q, shift_d;
    logic             active_q, active_d;
    logic             tx_q, tx_d;

    // bit_cnt counts the bit currently on the line: 0 start, 1..8 data, 9 stop.
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        active_d   = active_q;
        tx_d       = tx_q;
        if (!active_q) begin
            if (send) begin
                tx_d       = 1'b0;
                shift_d    = {1'b1, data};
                bit_cnt_d  = 4'd0;
                baud_cnt_d = '0;
                active_d   = 1'b1;
            end
        end else if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_d = '0;
            if (bit_cnt_q == 4'd9) begin
                active_d = 1'b0;
                tx_d     = 1'b1;
            end else begin
                tx_d      = shift_q[0];
                shift_d   = {1'b1, shift_q[8:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else begin
            baud_cnt_d = baud_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '1;
            active_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            active_q   <= active_d;
            tx_q       <= tx_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ~active_q;

endmodule

// File: rtl/out.sv
// Reads WORDS consecutive MIX words from memory and prints them as ASCII
// text over a UART, five characters per word, ending the block with CR LF.
module out
    import mix_pkg::*;
#(
    parameter int WORDS    = 3,
    parameter int BAUD_DIV = 104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] addressin,
    output logic [11:0] addressout,
    output logic        request,
    input  logic        load,
    input  logic [29:0] in,
    output logic        tx,
    output logic        busy,
    output logic [2:0]  dbg_state
);
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam logic [2:0] LAST_CHAR = 3'(CHARS_PER_WORD - 1);

    logic [2:0]       state_q, state_d;
    logic [11:0]      addr_q, addr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [29:0]      shift_q, shift_d;
    logic [2:0]       char_idx_q, char_idx_d;
    logic             launched_q, launched_d;
    logic             request_q, request_d;
    logic             busy_q, busy_d;

    logic       uart_send;
    logic       uart_ready;
    logic [7:0] uart_data;

    // Character handshake: send is honoured only while uart_ready is high; once
    // launched, ready is low until the stop bit completes, which marks the
    // character as done.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        shift_d    = shift_q;
        char_idx_d = char_idx_q;
        launched_d = launched_q;
        request_d  = 1'b0;
        busy_d     = busy_q;
        uart_send  = 1'b0;
        uart_data  = mix_to_ascii(shift_q[29:24]);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d    = addressin;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    request_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (load) begin
                    shift_d    = in;
                    char_idx_d = '0;
                    launched_d = 1'b0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!launched_q) begin
                    if (uart_ready) begin
                        uart_send  = 1'b1;
                        launched_d = 1'b1;
                    end
                end else if (uart_ready) begin
                    launched_d = 1'b0;
                    shift_d    = {shift_q[23:0], 6'b0};
                    if (char_idx_q == LAST_CHAR) begin
                        state_d = ST_NEXT;
                    end else begin
                        char_idx_d = char_idx_q + 3'd1;
                    end
                end
            end
            ST_NEXT: begin
                addr_d  = addr_q + 12'd1;
                count_d = count_q + 1'b1;
                if (count_d == CNT_W'(WORDS)) begin
                    char_idx_d = '0;
                    launched_d = 1'b0;
                    state_d    = ST_EOL;
                end else begin
                    request_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_EOL: begin
                uart_data = (char_idx_q == 3'd0) ? ASCII_CR : ASCII_LF;
                if (!launched_q) begin
                    if (uart_ready) begin
                        uart_send  = 1'b1;
                        launched_d = 1'b1;
                    end
                end else if (uart_ready) begin
                    launched_d = 1'b0;
                    if (char_idx_q == 3'd0) begin
                        char_idx_d = 3'd1;
                    end else begin
                        char_idx_d = '0;
                        busy_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            char_idx_q <= '0;
            launched_q <= 1'b0;
            request_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            char_idx_q <= char_idx_d;
            launched_q <= launched_d;
            request_q  <= request_d;
            busy_q     <= busy_d;
        end
    end

    uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart_tx (
        .clk  (clk),
        .reset(reset),
        .data (uart_data),
        .send (uart_send),
        .tx   (tx),
        .ready(uart_ready)
    );

    assign addressout = addr_q;
    assign request    = request_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_out.sv
// Bench for the MIX block printer: memory responder, UART decoder feeding a
// byte scoreboard, and one task per scenario.
module tb_out;
    import mix_pkg::*;

    localparam int WORDS    = 3;
    localparam int BAUD_DIV = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] addressin;
    logic [11:0] addressout;
    logic        request;
    logic        load;
    logic [29:0] in;
    logic        tx;
    logic        busy;
    logic [2:0]  dbg_state;

    out #(
        .WORDS   (WORDS),
        .BAUD_DIV(BAUD_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .addressin (addressin),
        .addressout(addressout),
        .request   (request),
        .load      (load),
        .in        (in),
        .tx        (tx),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [29:0] mem [4096];
    logic [7:0]  exp_q [$];
    int n_checks  = 0;
    int n_pass    = 0;
    int req_count = 0;
    int rx_count  = 0;
    bit resp_en   = 1'b1;
    bit mon_en    = 1'b1;

    // Reference translation, indexed directly by MIX code.
    function automatic logic [7:0] model_ascii(input int code);
        string tbl;
        tbl = " ABCDEFGHI?JKLMNOPQR??STUVWXYZ0123456789.,()+-*/=$<>@;:'";
        if (code < tbl.len()) return tbl[code];
        return 8'h3F;
    endfunction

    // Five character codes, written in the usual two-decimal-digit MIX notation.
    function automatic logic [29:0] pack5(input int a, input int b, input int c, input int d, input int e);
        return {6'(a), 6'(b), 6'(c), 6'(d), 6'(e)};
    endfunction

    task automatic push_block(input logic [11:0] base);
        logic [11:0] a;
        logic [29:0] w;
        for (int i = 0; i < WORDS; i++) begin
            a = base + 12'(i);
            w = mem[a];
            for (int k = 0; k < 5; k++) begin
                exp_q.push_back(model_ascii(int'(w[29 - 6*k -: 6])));
            end
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    initial begin : mem_responder
        logic [11:0] a;
        load = 1'b0;
        in   = '0;
        forever begin
            @(negedge clk);
            if (request === 1'b1) begin
                req_count++;
                a = addressout;
                if (resp_en) begin
                    repeat (1 + $urandom_range(0, 3)) @(negedge clk);
                    load = 1'b1;
                    in   = mem[a];
                    @(negedge clk);
                    load = 1'b0;
                    in   = 30'($urandom);
                end
            end
        end
    end

    initial begin : uart_monitor
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                repeat (BAUD_DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD_DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BAUD_DIV) @(negedge clk);
                n_checks++;
                if (tx !== 1'b1) $display("FAIL uart_stop: got %b want 1", tx);
                else n_pass++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL uart_byte: got %02h want nothing", b);
                end else begin
                    e = exp_q.pop_front();
                    if (b !== e) $display("FAIL uart_byte: got %02h want %02h", b, e);
                    else n_pass++;
                end
                rx_count++;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (addressout !== 12'd0) $display("FAIL reset_addr: got %0h want 0", addressout);
        else n_pass++;
        n_checks++;
        if (request !== 1'b0 || busy !== 1'b0) $display("FAIL reset_req_busy: got %b%b want 00", request, busy);
        else n_pass++;
        n_checks++;
        if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx);
        else n_pass++;
        n_checks++;
        if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_block_one;
        int cyc;
        bit saw50;
        mem[8]  = pack5(1, 2, 3, 4, 5);
        mem[9]  = pack5(6, 7, 10, 11, 12);
        mem[10] = pack5(6, 7, 10, 11, 12);
        push_block(12'd8);
        req_count = 0;
        rx_count  = 0;
        addressin = 12'd8;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (request !== 1'b1) $display("FAIL first_request: got %b want 1", request);
        else n_pass++;
        n_checks++;
        if (addressout !== 12'd8) $display("FAIL first_addr: got %0d want 8", addressout);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL first_busy: got %b want 1", busy);
        else n_pass++;
        repeat (9) @(negedge clk);
        addressin = 12'd50;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        addressin = 12'd0;
        saw50 = (addressout == 12'd50);
        cyc = 0;
        while (busy === 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (addressout == 12'd50) saw50 = 1'b1;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL block1_done: got busy=%b want 0", busy);
        else n_pass++;
        n_checks++;
        if (saw50) $display("FAIL ignored_start: got addressout=50 want never 50");
        else n_pass++;
        n_checks++;
        if (req_count != WORDS) $display("FAIL block1_requests: got %0d want %0d", req_count, WORDS);
        else n_pass++;
        n_checks++;
        if (rx_count != 17 || exp_q.size() != 0) $display("FAIL block1_bytes: got %0d rx %0d left want 17 rx 0 left", rx_count, exp_q.size());
        else n_pass++;
        n_checks++;
        if (addressout !== 12'd11) $display("FAIL block1_end_addr: got %0d want 11", addressout);
        else n_pass++;
    endtask

    // Starts in the current cycle, so calling it right after busy falls
    // exercises the first-IDLE-cycle start.
    task automatic test_block(input logic [11:0] base, input string tag);
        int cyc;
        logic [11:0] end_addr;
        end_addr = base + 12'(WORDS);
        push_block(base);
        req_count = 0;
        rx_count  = 0;
        addressin = base;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (request !== 1'b1 || addressout !== base)
            $display("FAIL %s_start: got req=%b addr=%0d want req=1 addr=%0d", tag, request, addressout, base);
        else n_pass++;
        cyc = 0;
        while (busy === 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s_done: got busy=%b want 0", tag, busy);
        else n_pass++;
        n_checks++;
        if (req_count != WORDS) $display("FAIL %s_requests: got %0d want %0d", tag, req_count, WORDS);
        else n_pass++;
        n_checks++;
        if (rx_count != 17 || exp_q.size() != 0) $display("FAIL %s_bytes: got %0d rx %0d left want 17 rx 0 left", tag, rx_count, exp_q.size());
        else n_pass++;
        n_checks++;
        if (addressout !== end_addr) $display("FAIL %s_end_addr: got %0d want %0d", tag, addressout, end_addr);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        mem[50] = pack5(31, 32, 33, 34, 35);
        mem[51] = pack5(36, 37, 30, 31, 32);
        mem[52] = pack5(36, 37, 30, 31, 32);
        test_block(12'd50, "digits");
    endtask

    task automatic test_wrap_and_table;
        @(negedge clk);
        mem[4094] = pack5(0, 55, 63, 56, 20);
        mem[4095] = pack5(21, 29, 39, 40, 9);
        mem[0]    = pack5(22, 30, 11, 19, 54);
        test_block(12'd4094, "wrap");
    endtask

    task automatic test_stall;
        int bad_state;
        int bad_tx;
        resp_en   = 1'b0;
        addressin = 12'd200;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad_state = 0;
        bad_tx    = 0;
        repeat (1000) begin
            @(negedge clk);
            if (dbg_state !== ST_WAIT) bad_state++;
            if (tx !== 1'b1) bad_tx++;
        end
        n_checks++;
        if (bad_state != 0) $display("FAIL stall_state: got %0d cycles off WAIT want 0", bad_state);
        else n_pass++;
        n_checks++;
        if (bad_tx != 0) $display("FAIL stall_tx: got %0d low cycles want 0", bad_tx);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL stall_busy: got %b want 1", busy);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stray_load;
        int bad;
        load = 1'b1;
        in   = pack5(1, 1, 1, 1, 1);
        @(negedge clk);
        load = 1'b0;
        bad  = 0;
        repeat (50) begin
            @(negedge clk);
            if (dbg_state !== ST_IDLE || busy !== 1'b0 || request !== 1'b0 || tx !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL stray_load: got %0d disturbed cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid_char;
        int cyc;
        int bad;
        mon_en    = 1'b0;
        addressin = 12'd8;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (tx !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (tx !== 1'b0) $display("FAIL midchar_start_bit: got tx=%b want 0", tx);
        else n_pass++;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || request !== 1'b0)
            $display("FAIL midchar_reset: got tx=%b busy=%b req=%b want 1 0 0", tx, busy, request);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || dbg_state !== ST_IDLE) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL midchar_no_resume: got %0d active cycles want 0", bad);
        else n_pass++;
        mon_en = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        addressin = '0;
        test_reset();
        test_block_one();
        test_back_to_back();
        test_wrap_and_table();
        test_stall();
        test_stray_load();
        test_reset_mid_char();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
